// File: rtl/spdif_tx_pkg.sv
// Shared constants and types for the S/PDIF transmitter.
package spdif_tx_pkg;

   // Preamble patterns, sent MSB first, XORed with the line level held before slot 0
   localparam logic [7:0] PRE_B = 8'b1110_1000;
   localparam logic [7:0] PRE_M = 8'b1110_0010;
   localparam logic [7:0] PRE_W = 8'b1110_0100;

   localparam int SPDIF_FRAMES_PER_BLOCK = 192;
   localparam int SPDIF_SLOTS            = 32;

   typedef struct packed {
      logic [23:0] l;
      logic [23:0] r;
   } spdif_pair_t;

endpackage

// File: rtl/spdif_bmc_enc.sv
// Biphase-mark line encoder. Advances one unit interval per ui_tick.
module spdif_bmc_enc (
   input  logic clk,
   input  logic resetb,
   input  logic clr,
   input  logic ui_tick,
   input  logic pre_sel,
   input  logic pre_first,
   input  logic pre_bit,
   input  logic cell_first,
   input  logic cell_bit,
   output logic line
);

   logic line_q, line_d;
   logic ref_q, ref_d;
   logic pre_ref;

   // Next line level: preamble bits are relative to the level before slot 0,
   // data cells toggle at cell start and again mid-cell for a 1.
   always_comb begin
      line_d  = line_q;
      ref_d   = ref_q;
      pre_ref = pre_first ? line_q : ref_q;
      if (clr) begin
         line_d = 1'b0;
         ref_d  = 1'b0;
      end else if (ui_tick) begin
         if (pre_sel) begin
            ref_d  = pre_ref;
            line_d = pre_bit ^ pre_ref;
         end else if (cell_first || cell_bit) begin
            line_d = ~line_q;
         end
      end
   end

   // Line level and latched preamble reference.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         line_q <= 1'b0;
         ref_q  <= 1'b0;
      end else begin
         line_q <= line_d;
         ref_q  <= ref_d;
      end
   end

   assign line = line_q;

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF consumer transmitter: UI divider, slot/frame counters, one-entry
// sample buffer and subframe assembly feeding the biphase-mark encoder.
module spdif_tx
   import spdif_tx_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int SAMPLE_W = 24
) (
   input  logic                clk,
   input  logic                resetb,
   input  logic                enable,
   input  logic [31:0]         cs_word,
   input  logic [SAMPLE_W-1:0] sample_l,
   input  logic [SAMPLE_W-1:0] sample_r,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                spdif_out,
   output logic                frame_start,
   output logic                block_start,
   output logic                underrun
);

   localparam int              DIV_W      = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_TC     = DIV_W'(1);
   localparam logic [7:0]      LAST_FRAME = 8'(SPDIF_FRAMES_PER_BLOCK - 1);

   logic              run_q, run_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [6:0]        ui_q, ui_d;
   logic [7:0]        frame_q, frame_d;
   spdif_pair_t       buf_q, buf_d;
   spdif_pair_t       act_q, act_d;
   logic              full_q, full_d;
   logic              vflag_q, vflag_d;
   logic              cs_bit_q, cs_bit_d;
   logic              frame_start_q, frame_start_d;
   logic              block_start_q, block_start_d;
   logic              underrun_q, underrun_d;

   logic                   ui_tick;
   logic                   frame_tick;
   logic                   accept;
   logic [4:0]             slot;
   logic [23:0]            cur_sample;
   logic [SPDIF_SLOTS-1:0] sub_bits;
   logic [7:0]             pre_pat;
   logic                   pre_sel;
   logic                   pre_first;
   logic                   pre_bit;
   logic                   cell_bit;

   // div_q parks at 0 while idle; the first reload costs one clock so the
   // first UI lands CLK_DIV clocks after enable is sampled high.
   assign ui_tick    = run_q && (div_q == DIV_TC);
   assign frame_tick = ui_tick && (ui_q == 7'd0);
   assign accept     = enable && sample_valid && !full_q;

   // Divider, UI/frame counters, buffer handshake and frame-start unload.
   always_comb begin
      run_d         = enable;
      div_d         = div_q;
      ui_d          = ui_q;
      frame_d       = frame_q;
      buf_d         = buf_q;
      full_d        = full_q;
      act_d         = act_q;
      vflag_d       = vflag_q;
      cs_bit_d      = cs_bit_q;
      frame_start_d = 1'b0;
      block_start_d = 1'b0;
      underrun_d    = 1'b0;
      if (!enable) begin
         div_d    = '0;
         ui_d     = '0;
         frame_d  = '0;
         buf_d    = '0;
         full_d   = 1'b0;
         act_d    = '0;
         vflag_d  = 1'b0;
         cs_bit_d = 1'b0;
      end else begin
         if (run_q) begin
            div_d = (div_q == '0) ? DIV_RELOAD : div_q - DIV_TC;
         end
         if (ui_tick) begin
            ui_d = ui_q + 7'd1;
            if (ui_q == 7'd127) begin
               frame_d = (frame_q == LAST_FRAME) ? 8'd0 : frame_q + 8'd1;
            end
         end
         if (frame_tick) begin
            act_d         = full_q ? buf_q : '0;
            vflag_d       = !full_q;
            cs_bit_d      = (frame_q < 8'd32) && cs_word[frame_q[4:0]];
            full_d        = 1'b0;
            frame_start_d = 1'b1;
            block_start_d = (frame_q == 8'd0);
            underrun_d    = !full_q;
         end
         // A pair arriving on the unload clock refills the buffer.
         if (accept) begin
            buf_d  = {sample_l, sample_r};
            full_d = 1'b1;
         end
      end
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         run_q         <= 1'b0;
         div_q         <= '0;
         ui_q          <= '0;
         frame_q       <= '0;
         buf_q         <= '0;
         full_q        <= 1'b0;
         act_q         <= '0;
         vflag_q       <= 1'b0;
         cs_bit_q      <= 1'b0;
         frame_start_q <= 1'b0;
         block_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         run_q         <= run_d;
         div_q         <= div_d;
         ui_q          <= ui_d;
         frame_q       <= frame_d;
         buf_q         <= buf_d;
         full_q        <= full_d;
         act_q         <= act_d;
         vflag_q       <= vflag_d;
         cs_bit_q      <= cs_bit_d;
         frame_start_q <= frame_start_d;
         block_start_q <= block_start_d;
         underrun_q    <= underrun_d;
      end
   end

   // Subframe assembly: ui_q[6] selects right, ui_q[5:1] is the slot, ui_q[0] the half-cell.
   assign slot       = ui_q[5:1];
   assign cur_sample = ui_q[6] ? act_q.r : act_q.l;
   assign sub_bits   = {^{cs_bit_q, vflag_q, cur_sample}, cs_bit_q, 1'b0, vflag_q,
                        cur_sample, 4'b0000};
   assign pre_pat    = ui_q[6] ? PRE_W : ((frame_q == 8'd0) ? PRE_B : PRE_M);
   assign pre_sel    = (ui_q[5:3] == 3'd0);
   assign pre_first  = (ui_q[5:0] == 6'd0);
   assign pre_bit    = pre_pat[~ui_q[2:0]];
   assign cell_bit   = sub_bits[slot];

   spdif_bmc_enc u_enc (
      .clk        (clk),
      .resetb     (resetb),
      .clr        (!enable),
      .ui_tick    (ui_tick),
      .pre_sel    (pre_sel),
      .pre_first  (pre_first),
      .pre_bit    (pre_bit),
      .cell_first (!ui_q[0]),
      .cell_bit   (cell_bit),
      .line       (spdif_out)
   );

   assign sample_ready = !full_q;
   assign frame_start  = frame_start_q;
   assign block_start  = block_start_q;
   assign underrun     = underrun_q;

endmodule

// File: tb/tb_spdif_tx.sv
// Testbench for spdif_tx: table-driven single-frame vectors plus sequences
// for underrun, enable drop, mid-frame reset and block streaming.
module tb_spdif_tx;

   localparam int DIV = 2;
   localparam logic [7:0] EXP_B = 8'b1110_1000;
   localparam logic [7:0] EXP_M = 8'b1110_0010;
   localparam logic [7:0] EXP_W = 8'b1110_0100;

   logic        clk = 1'b0;
   logic        resetb = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] cs_word = '0;
   logic [23:0] sample_l = '0;
   logic [23:0] sample_r = '0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic        spdif_out;
   logic        frame_start;
   logic        block_start;
   logic        underrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spdif_tx #(.CLK_DIV(DIV), .SAMPLE_W(24)) dut (
      .clk          (clk),
      .resetb       (resetb),
      .enable       (enable),
      .cs_word      (cs_word),
      .sample_l     (sample_l),
      .sample_r     (sample_r),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .spdif_out    (spdif_out),
      .frame_start  (frame_start),
      .block_start  (block_start),
      .underrun     (underrun)
   );

   typedef struct packed {
      logic [23:0] l;
      logic [23:0] r;
      logic [31:0] cs;
      logic        exp_c;
      logic        exp_pl;
      logic        exp_pr;
   } vec_t;

   vec_t vecs[4];

   logic [127:0] fr_ui;
   logic         fr_pre;
   int           fr_und, fr_blk, fr_acc, fr_rdy_lo, fs_lat;
   logic [27:0]  dl, dr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic do_reset;
      @(negedge clk);
      enable       = 1'b0;
      sample_valid = 1'b0;
      resetb       = 1'b0;
      repeat (2) @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);
   endtask

   // Waits for frame_start; fs_lat = negedges consumed, fr_pre = line level before it.
   task automatic wait_fs;
      logic last;
      last = spdif_out;
      for (int n = 1; n <= 4000; n++) begin
         @(negedge clk);
         if (frame_start) begin
            fs_lat = n;
            fr_pre = last;
            return;
         end
         last = spdif_out;
      end
      checks++;
      errors++;
      $display("FAIL frame_start_timeout actual=none required=pulse");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "frame_start never seen");
   endtask

   // Called on the negedge where frame_start is high; samples all 128 UI.
   task automatic cap_frame;
      fr_und = 0; fr_blk = 0; fr_acc = 0; fr_rdy_lo = 0;
      for (int c = 0; c < 128 * DIV; c++) begin
         if (c > 0) @(negedge clk);
         if (c % DIV == 0) fr_ui[c / DIV] = spdif_out;
         fr_und    += int'(underrun);
         fr_blk    += int'(block_start);
         fr_acc    += int'(sample_valid & sample_ready & enable);
         fr_rdy_lo += int'(!sample_ready);
      end
   endtask

   function automatic void dec_sub(input logic [63:0] u, input logic ref_lvl,
                                   output logic [7:0] pre, output logic [27:0] d,
                                   output logic ok);
      logic prev;
      ok = 1'b1;
      d  = '0;
      for (int k = 0; k < 8; k++) pre[7-k] = u[k] ^ ref_lvl;
      prev = u[7];
      for (int s = 4; s < 32; s++) begin
         if (u[2*s] == prev) ok = 1'b0;
         d[s-4] = u[2*s] ^ u[2*s+1];
         prev   = u[2*s+1];
      end
   endfunction

   task automatic check_frame(input string tag, input logic [7:0] pre_exp,
                              input logic [23:0] l_exp, input logic [23:0] r_exp,
                              input logic v_exp, input logic c_exp);
      logic [7:0] pl, pr;
      logic okl, okr;
      dec_sub(fr_ui[63:0], fr_pre, pl, dl, okl);
      dec_sub(fr_ui[127:64], fr_ui[63], pr, dr, okr);
      chk({tag, "_pre_l"}, 32'(pl), 32'(pre_exp));
      chk({tag, "_pre_r"}, 32'(pr), 32'(EXP_W));
      chk({tag, "_bmc"}, {30'd0, okl, okr}, 32'd3);
      chk({tag, "_l"}, 32'(dl[23:0]), 32'(l_exp));
      chk({tag, "_r"}, 32'(dr[23:0]), 32'(r_exp));
      chk({tag, "_vucl"}, 32'(dl[26:24]), {29'd0, c_exp, 1'b0, v_exp});
      chk({tag, "_vucr"}, 32'(dr[26:24]), {29'd0, c_exp, 1'b0, v_exp});
      chk({tag, "_even"}, {30'd0, ^dl, ^dr}, 32'd0);
   endtask

   initial begin
      logic [7:0] raw;
      vecs[0] = '{24'h000001, 24'h000000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{24'hFFFFFF, 24'h800000, 32'h0000_0001, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{24'h123456, 24'hABCDEF, 32'h0000_0002, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{24'h000000, 24'h000003, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};

      // reset state
      #2 resetb = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out", 32'(spdif_out), 32'd0);
      chk("rst_ready", 32'(sample_ready), 32'd1);
      chk("rst_pulses", {29'd0, frame_start, block_start, underrun}, 32'd0);

      // single-frame vectors with a preloaded pair
      for (int i = 0; i < 4; i++) begin
         do_reset();
         cs_word = vecs[i].cs; sample_l = vecs[i].l; sample_r = vecs[i].r;
         sample_valid = 1'b1; enable = 1'b1;
         @(negedge clk);
         chk("vec_ready_full", 32'(sample_ready), 32'd0);
         sample_valid = 1'b0;
         wait_fs();
         chk("vec_latency", fs_lat, DIV);
         cap_frame();
         for (int k = 0; k < 8; k++) raw[7-k] = fr_ui[k];
         chk("vec_raw_b", 32'(raw), 32'(EXP_B));
         chk("vec_blk_und", {fr_blk[15:0], fr_und[15:0]}, 32'h0001_0000);
         check_frame("vec", EXP_B, vecs[i].l, vecs[i].r, 1'b0, vecs[i].exp_c);
         chk("vec_par_l", 32'(dl[27]), 32'(vecs[i].exp_pl));
         chk("vec_par_r", 32'(dr[27]), 32'(vecs[i].exp_pr));
      end

      // underrun: one pair then nothing
      do_reset();
      cs_word = '0; sample_l = 24'h00000F; sample_r = 24'h0000F0;
      sample_valid = 1'b1; enable = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      wait_fs();
      cap_frame();
      chk("ur_f0_und", fr_und, 0);
      check_frame("ur_f0", EXP_B, 24'h00000F, 24'h0000F0, 1'b0, 1'b0);
      for (int f = 1; f <= 2; f++) begin
         wait_fs();
         chk("ur_period", fs_lat, 1);
         cap_frame();
         chk("ur_und_once", fr_und, 1);
         chk("ur_blk", fr_blk, 0);
         chk("ur_ready_high", fr_rdy_lo, 0);
         check_frame("ur", EXP_M, 24'h0, 24'h0, 1'b1, 1'b0);
      end

      // enable drop: idle line, no accepts
      @(negedge clk);
      enable = 1'b0; sample_valid = 1'b1;
      @(negedge clk);
      chk("dis_out", 32'(spdif_out), 32'd0);
      chk("dis_ready", 32'(sample_ready), 32'd1);
      repeat (4) @(negedge clk);
      chk("dis_no_accept", {30'd0, sample_ready, frame_start}, 32'd2);

      // asynchronous reset at UI 70 of a frame
      do_reset();
      sample_l = 24'h00ABCD; sample_r = 24'h001234; sample_valid = 1'b1; enable = 1'b1;
      wait_fs();
      repeat (70 * DIV) @(negedge clk);
      chk("mid_ready_full", 32'(sample_ready), 32'd0);
      #1 resetb = 1'b0;
      #1;
      chk("mid_rst_out", 32'(spdif_out), 32'd0);
      chk("mid_rst_ready", 32'(sample_ready), 32'd1);
      @(negedge clk);
      resetb = 1'b1;
      wait_fs();
      chk("mid_latency", fs_lat, DIV + 1);
      cap_frame();
      chk("mid_blk", fr_blk, 1);
      check_frame("mid", EXP_B, 24'h00ABCD, 24'h001234, 1'b0, 1'b0);

      // streaming across a block boundary with cs_word bit 2 set
      do_reset();
      cs_word = 32'h0000_0004; sample_l = 24'hFFFFFF; sample_r = 24'h800000;
      sample_valid = 1'b1; enable = 1'b1;
      for (int f = 0; f < 195; f++) begin
         wait_fs();
         chk("st_period", fs_lat, (f == 0) ? DIV + 1 : 1);
         cap_frame();
         chk("st_blk", fr_blk, (f % 192 == 0) ? 1 : 0);
         chk("st_und", fr_und, 0);
         chk("st_acc", fr_acc, 1);
         check_frame("st", (f % 192 == 0) ? EXP_B : EXP_M, 24'hFFFFFF, 24'h800000,
                     1'b0, (f % 192 == 2));
      end

      enable = 1'b0;
      sample_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
